mem_access_controller: RTL
==========================

// Module: mem_access_controller
// PURPOSE
//  Pipeline-side initiator for the byte-lane BRAM addresser. Accepts one load/store request from the
//  execute/memory register, drives address/code/store-data to the addresser for one access cycle, then
//  returns load data aligned and sign/zero-extended to the writeback stage.
//  Also range-checks addresses so an access never wraps inside the 4-BRAM array.
// PARAMETERS
//  ADDR_BITS  18  byte-address width of the BRAM array; valid range is 0 .. 2^ADDR_BITS-1
// PORTS
//  CLOCK_50           in   1   system clock; all state updates on the rising edge
//  reset              in   1   synchronous, active-high reset
//  req_valid          in   1   request present
//  req_ready          out  1   controller accepts request this cycle
//  req_store          in   1   1 = store, 0 = load
//  req_size           in   2   00 byte, 01 halfword, 10 word, 11 illegal
//  req_signed         in   1   loads only: 1 = sign-extend, 0 = zero-extend
//  req_addr           in   32  byte address, any alignment
//  req_wdata          in   32  store data, right-justified (byte in [7:0], half in [15:0])
//  req_rd             in   5   destination register tag, returned unchanged
//  rsp_valid          out  1   response present
//  rsp_ready          in   1   writeback consumes response
//  rsp_rdata          out  32  extended load data; 0 for stores and faults
//  rsp_rd             out  5   echoed tag
//  rsp_is_load        out  1   response belongs to a load
//  rsp_fault          out  1   illegal size or out-of-range access; no memory effect
//  mem_address        out  32  to addresser memory_address
//  mem_access_code    out  5   to addresser: [4] store, [3:0] byte enable
//  mem_data_to_store  out  32  to addresser data_to_store
//  mem_read_data      in   32  from addresser writeback_register_data
// BEHAVIOUR
//  - FSM: IDLE -> ACCESS -> RESP. req_ready = (IDLE) | (RESP & rsp_ready).
//  - Handshake: a request is accepted when req_valid & req_ready; all req_* fields are registered.
//  - Fault check at accept: req_size==11, or req_addr + nbytes - 1 >= 2^ADDR_BITS (compute at 33 bits).
//    Faulting request goes straight to RESP with rsp_fault=1, rsp_rdata=0; never enters ACCESS.
//  - Lane mapping (big-endian; byte at A is lane [31:24]):
//    byte: code[3:0]=1000, data_to_store[31:24]=wdata[7:0]
//    half: 1100, [31:16]=wdata[15:0]
//    word: 1111, [31:0]=wdata
//    Unused lanes are driven 0.
//  - ACCESS (exactly one cycle): mem_address/mem_data_to_store come from the request registers.
//    mem_access_code[4] = stored store bit. BRAMs write on the falling edge inside ACCESS.
//  - Outside ACCESS, mem_access_code = 5'b0 (no writes); mem_address holds its last value.
//  - Load capture: mem_read_data is registered on the rising edge ending ACCESS.
//    Extraction: byte <= [31:24], half <= [31:16], word <= [31:0]; extended per req_signed.
//  - RESP: rsp_* are registered and held stable while rsp_valid & !rsp_ready.
//    On rsp_ready: a new valid request goes to ACCESS (or back to RESP if faulting); otherwise IDLE.
//  - Latency: accept to rsp_valid is 2 cycles; throughput is 1 op per 2 cycles with rsp_ready held high.
//  - Stores also respond (rsp_is_load=0, rsp_rdata=0) so the pipeline knows completion.
//  - Reset values: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_rd 0, rsp_is_load 0, rsp_fault 0,
//    mem_access_code 0, mem_address 0, mem_data_to_store 0.
//  - Reset mid-operation: a store whose ACCESS cycle has started has already written (the falling edge
//    precedes the reset edge); any pending response is discarded and the next cycle is IDLE.
//  - Address wrap at 2^ADDR_BITS is therefore unreachable through this block.
// STRUCTURE
//  - mem_pkg: SIZE_BYTE/HALF/WORD encodings, CODE_STORE_BIT=4, byte-enable constants,
//    FSM state encodings.
//  - Sub-module mem_load_format: combinational lane extraction plus sign/zero extension
//    (size, signed, raw32 -> data32).
// TESTING
//  1. store word 0xDEADBEEF @0x101; load word @0x101 -> rsp_rdata 0xDEADBEEF, rsp_fault 0.
//  2. store byte 0x80 @0x6; load signed byte @0x6 -> 0xFFFFFF80; unsigned -> 0x00000080.
//  3. store half 0x1234 @0x3 (crosses word); load signed half @0x3 -> 0x00001234;
//     load word @0x0 -> 0xxxxxxx12 in [7:0], with 0x34 at @0x4.
//  4. load word @0x3FFFE -> rsp_fault 1, rsp_rdata 0; store byte @0x40000 -> fault,
//     mem_access_code stays 0.
//  5. two back-to-back loads, rsp_ready low 3 cycles -> rsp_* stable, req_ready 0;
//     then 1 op per 2 cycles.
//  6. reset asserted during RESP -> rsp_valid 0 next cycle, req_ready 1, all outputs at reset values.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the load/store initiator: access sizes, byte-lane enables,
// FSM states and small lane-mapping helpers.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    localparam int CODE_STORE_BIT = 4;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_BYTE = 4'b1000;
    localparam logic [3:0] BE_HALF = 4'b1100;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    function automatic logic [3:0] size_to_be(input logic [1:0] size);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = BE_BYTE;
            SIZE_HALF: be = BE_HALF;
            SIZE_WORD: be = BE_WORD;
            default:   be = BE_NONE;
        endcase
        return be;
    endfunction

    // Offset of the last byte touched by an access (nbytes - 1).
    function automatic logic [2:0] size_to_last(input logic [1:0] size);
        logic [2:0] last;
        case (size)
            SIZE_BYTE: last = 3'd0;
            SIZE_HALF: last = 3'd1;
            SIZE_WORD: last = 3'd3;
            default:   last = 3'd3;
        endcase
        return last;
    endfunction

    // Big-endian lane placement: the byte at the access address lives in [31:24].
    function automatic logic [31:0] lane_map(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] lanes;
        case (size)
            SIZE_BYTE: lanes = {wdata[7:0], 24'd0};
            SIZE_HALF: lanes = {wdata[15:0], 16'd0};
            SIZE_WORD: lanes = wdata;
            default:   lanes = 32'd0;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/mem_load_format.sv
// Load-data formatter: picks the addressed lanes out of the raw BRAM word and
// sign- or zero-extends them to 32 bits.
module mem_load_format
    import mem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [31:0] i_raw,
    output logic [31:0] o_data
);

    // Lane extraction and extension
    always_comb begin
        o_data = 32'd0;
        case (i_size)
            SIZE_BYTE: o_data = {{24{i_signed & i_raw[31]}}, i_raw[31:24]};
            SIZE_HALF: o_data = {{16{i_signed & i_raw[31]}}, i_raw[31:16]};
            SIZE_WORD: o_data = i_raw;
            default:   o_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_access_controller.sv
// Load/store initiator for the byte-lane BRAM addresser: one-cycle access window,
// range checking against the BRAM array and formatted load responses.
module mem_access_controller
    import mem_pkg::*;
#(
    parameter int ADDR_BITS = 18
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [4:0]  rsp_rd,
    output logic        rsp_is_load,
    output logic        rsp_fault,
    output logic [31:0] mem_address,
    output logic [4:0]  mem_access_code,
    output logic [31:0] mem_data_to_store,
    input  logic [31:0] mem_read_data
);

    localparam logic [32:0] ADDR_LIMIT = 33'd1 << ADDR_BITS;

    state_t      r_state;
    state_t      w_next_state;
    logic        w_req_ready;
    logic        w_accept;
    logic        w_fault;
    logic [32:0] w_end_addr;
    logic [31:0] w_load_data;

    logic        r_store;
    logic        r_signed;
    logic [1:0]  r_size;
    logic [4:0]  r_rd;

    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic [4:0]  r_rsp_rd;
    logic        r_rsp_is_load;
    logic        r_rsp_fault;
    logic [31:0] r_mem_address;
    logic [4:0]  r_mem_code;
    logic [31:0] r_mem_wdata;

    // 33-bit end address so a request near 2^32 cannot wrap past the check.
    assign w_end_addr = {1'b0, req_addr} + {30'd0, size_to_last(req_size)};
    assign w_fault    = (req_size == SIZE_ILLEGAL) || (w_end_addr >= ADDR_LIMIT);
    assign w_accept   = req_valid & w_req_ready;

    // Next-state and request-ready decode
    always_comb begin
        w_req_ready  = 1'b0;
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid) begin
                    w_next_state = w_fault ? ST_RESP : ST_ACCESS;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ACCESS: w_next_state = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    w_req_ready = 1'b1;
                    if (req_valid) begin
                        w_next_state = w_fault ? ST_RESP : ST_ACCESS;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end else begin
                    w_next_state = ST_RESP;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // Request capture
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_store  <= 1'b0;
            r_signed <= 1'b0;
            r_size   <= SIZE_BYTE;
            r_rd     <= 5'd0;
        end else if (w_accept) begin
            r_store  <= req_store;
            r_signed <= req_signed;
            r_size   <= req_size;
            r_rd     <= req_rd;
        end
    end

    // Addresser drive: access code is live only for the cycle after a clean accept
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_mem_address <= 32'd0;
            r_mem_code    <= 5'd0;
            r_mem_wdata   <= 32'd0;
        end else if (w_accept && !w_fault) begin
            r_mem_address <= req_addr;
            r_mem_code    <= {req_store, size_to_be(req_size)};
            r_mem_wdata   <= req_store ? lane_map(req_size, req_wdata) : 32'd0;
        end else begin
            r_mem_code    <= 5'd0;
        end
    end

    mem_load_format u_load_format (
        .i_size   (r_size),
        .i_signed (r_signed),
        .i_raw    (mem_read_data),
        .o_data   (w_load_data)
    );

    // Response registers; held while the writeback stage stalls
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= 32'd0;
            r_rsp_rd      <= 5'd0;
            r_rsp_is_load <= 1'b0;
            r_rsp_fault   <= 1'b0;
        end else if (w_accept && w_fault) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= 32'd0;
            r_rsp_rd      <= req_rd;
            r_rsp_is_load <= !req_store;
            r_rsp_fault   <= 1'b1;
        end else if (r_state == ST_ACCESS) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= r_store ? 32'd0 : w_load_data;
            r_rsp_rd      <= r_rd;
            r_rsp_is_load <= !r_store;
            r_rsp_fault   <= 1'b0;
        end else if ((r_state == ST_RESP) && rsp_ready) begin
            r_rsp_valid   <= 1'b0;
        end
    end

    assign req_ready         = w_req_ready;
    assign rsp_valid         = r_rsp_valid;
    assign rsp_rdata         = r_rsp_rdata;
    assign rsp_rd            = r_rsp_rd;
    assign rsp_is_load       = r_rsp_is_load;
    assign rsp_fault         = r_rsp_fault;
    assign mem_address       = r_mem_address;
    assign mem_access_code   = r_mem_code;
    assign mem_data_to_store = r_mem_wdata;

endmodule
